// File: rtl/mem_arbiter_if.sv
// Request/response and memory bus bundle for mem_arbiter.
// The arbiter uses the slave view; the pipeline-plus-memory environment uses the master view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          busy;
    logic          owner;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, busy, owner
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch (I) and data (D); D has priority with a fetch-starvation override.
// Define ARB_STATS_EN to add saturating grant / starvation-override counters.
module mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int WAIT   = 1,
    parameter int STARVE = 4
) (
    input  logic         clk,
    input  logic         clr,
    mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]  i_grant_cnt,
    output logic [15:0]  d_grant_cnt,
    output logic [15:0]  starve_hit_cnt
`endif
);
    localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam int SW = $clog2(STARVE + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;

    logic starved;
    logic grant_i;
    logic grant_d;

    // A starved fetch only overrides data while fetch is actually requesting.
    assign starved = bus.i_req && (int'(starve_q) >= STARVE);
    assign grant_d = (state_q == IDLE) && bus.d_req && !starved;
    assign grant_i = (state_q == IDLE) && bus.i_req && !grant_d;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = BUSY_D;
                    addr_d  = bus.d_addr;
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                    wcnt_d  = CW'(WAIT - 1);
                end else if (grant_i) begin
                    state_d = BUSY_I;
                    addr_d  = bus.i_addr;
                    we_d    = 1'b0;
                    wdata_d = bus.d_wdata;
                    wcnt_d  = CW'(WAIT - 1);
                end
            end
            BUSY_I, BUSY_D: begin
                if (wcnt_q == '0) begin
                    state_d = IDLE;
                    if (state_q == BUSY_I) begin
                        i_rdata_d = bus.m_rdata;
                        i_ack_d   = 1'b1;
                    end else begin
                        if (!we_q) begin
                            d_rdata_d = bus.m_rdata;
                        end
                        d_ack_d = 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Waiting fetch ages while D owns the memory or wins arbitration; holds while I itself is served.
    always_comb begin
        starve_d = starve_q;
        if (!bus.i_req || grant_i) begin
            starve_d = '0;
        end else if ((state_q != BUSY_I) && (int'(starve_q) < STARVE)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            starve_q  <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
        end
    end

    assign bus.m_en    = (state_q != IDLE);
    assign bus.m_we    = (state_q == BUSY_D) && we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.owner   = (state_q == BUSY_D);

`ifdef ARB_STATS_EN
    logic [15:0] i_grant_cnt_q, i_grant_cnt_d;
    logic [15:0] d_grant_cnt_q, d_grant_cnt_d;
    logic [15:0] starve_hit_cnt_q, starve_hit_cnt_d;

    // An I grant while D is also requesting can only come from the starvation override.
    always_comb begin
        i_grant_cnt_d    = i_grant_cnt_q;
        d_grant_cnt_d    = d_grant_cnt_q;
        starve_hit_cnt_d = starve_hit_cnt_q;
        if (grant_i && (i_grant_cnt_q != 16'hFFFF)) begin
            i_grant_cnt_d = i_grant_cnt_q + 16'd1;
        end
        if (grant_d && (d_grant_cnt_q != 16'hFFFF)) begin
            d_grant_cnt_d = d_grant_cnt_q + 16'd1;
        end
        if (grant_i && bus.d_req && (starve_hit_cnt_q != 16'hFFFF)) begin
            starve_hit_cnt_d = starve_hit_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            i_grant_cnt_q    <= '0;
            d_grant_cnt_q    <= '0;
            starve_hit_cnt_q <= '0;
        end else begin
            i_grant_cnt_q    <= i_grant_cnt_d;
            d_grant_cnt_q    <= d_grant_cnt_d;
            starve_hit_cnt_q <= starve_hit_cnt_d;
        end
    end

    assign i_grant_cnt    = i_grant_cnt_q;
    assign d_grant_cnt    = d_grant_cnt_q;
    assign starve_hit_cnt = starve_hit_cnt_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a grant-schedule model of the arbiter.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int WAIT   = 2;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef ARB_STATS_EN
    logic [15:0] i_grant_cnt, d_grant_cnt, starve_hit_cnt;
`endif

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT), .STARVE(STARVE)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
`ifdef ARB_STATS_EN
        ,
        .i_grant_cnt(i_grant_cnt),
        .d_grant_cnt(d_grant_cnt),
        .starve_hit_cnt(starve_hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Memory environment: read data is only valid in the last cycle of an access; writes land then too.
    logic [DW-1:0] mem [16];
    int acc_cnt = 0;
    always @(posedge clk) begin
        if (bus.m_en && bus.m_we && acc_cnt == WAIT - 1) mem[bus.m_addr[5:2]] <= bus.m_wdata;
        acc_cnt <= bus.m_en ? acc_cnt + 1 : 0;
    end
    assign bus.m_rdata = (bus.m_en && acc_cnt == WAIT - 1) ? mem[bus.m_addr[5:2]]
                                                           : (32'hBAD0_0000 | DW'(acc_cnt));

    // Reference model: a grant at cycle g occupies cycles g+1..g+WAIT and acks at g+WAIT+1.
    logic [DW-1:0] shadow [16];
    int            bfrom = -10, bto = -10, ack_at = -10;
    bit            gown = 1'b0, gwe = 1'b0, ackown = 1'b0, ack_rd = 1'b0;
    logic [AW-1:0] gaddr = '0;
    logic [DW-1:0] gwdata = '0, ack_data = '0, mi_rdata = '0, md_rdata = '0;
    int            scnt = 0;
    int            m_ig = 0, m_dg = 0, m_sh = 0;
    bit            model_on = 1'b0;

    always @(negedge clk) begin
        if (model_on) begin
            bit busy_e, ack_now, gi, gd;
            busy_e  = (cyc >= bfrom) && (cyc <= bto);
            ack_now = (cyc == ack_at);
            if (ack_now && ack_rd) begin
                if (ackown) md_rdata = ack_data;
                else        mi_rdata = ack_data;
            end
            chk("busy",    32'(bus.busy),  32'(busy_e));
            chk("m_en",    32'(bus.m_en),  32'(busy_e));
            chk("m_we",    32'(bus.m_we),  32'(busy_e && gown && gwe));
            chk("m_addr",  bus.m_addr,     gaddr);
            if (busy_e) chk("owner", 32'(bus.owner), 32'(gown));
            if (busy_e && gown && gwe) chk("m_wdata", bus.m_wdata, gwdata);
            chk("i_ack",   32'(bus.i_ack), 32'(ack_now && !ackown));
            chk("d_ack",   32'(bus.d_ack), 32'(ack_now && ackown));
            chk("i_rdata", bus.i_rdata,    mi_rdata);
            chk("d_rdata", bus.d_rdata,    md_rdata);
`ifdef ARB_STATS_EN
            chk("i_grant_cnt",    32'(i_grant_cnt),    m_ig);
            chk("d_grant_cnt",    32'(d_grant_cnt),    m_dg);
            chk("starve_hit_cnt", 32'(starve_hit_cnt), m_sh);
`endif
            if (cyc == bto && gown && gwe) shadow[gaddr[5:2]] = gwdata;
            if (clr) begin
                bfrom = -10; bto = -10; ack_at = -10;
                gown = 1'b0; gwe = 1'b0; gaddr = '0;
                mi_rdata = '0; md_rdata = '0; scnt = 0;
                m_ig = 0; m_dg = 0; m_sh = 0;
            end else begin
                gd = !busy_e && bus.d_req && !(bus.i_req && scnt >= STARVE);
                gi = !busy_e && bus.i_req && !gd;
                if (!bus.i_req || gi) scnt = 0;
                else if (!(busy_e && !gown) && scnt < STARVE) scnt++;
                if (gd || gi) begin
                    gown     = gd;
                    gaddr    = gd ? bus.d_addr : bus.i_addr;
                    gwe      = gd && bus.d_we;
                    gwdata   = bus.d_wdata;
                    bfrom    = cyc + 1;
                    bto      = cyc + WAIT;
                    ack_at   = cyc + WAIT + 1;
                    ackown   = gd;
                    ack_rd   = !gwe;
                    ack_data = shadow[gaddr[5:2]];
                    if (gi && m_ig < 65535) m_ig++;
                    if (gd && m_dg < 65535) m_dg++;
                    if (gi && bus.d_req && m_sh < 65535) m_sh++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            mem[k]    = 32'h1000_0000 + 32'(k) * 32'h11;
            shadow[k] = 32'h1000_0000 + 32'(k) * 32'h11;
        end
        mem[1]    = 32'h8C01_0004;
        shadow[1] = 32'h8C01_0004;

        // Reset held two cycles with both requests up; D must win first.
        bus.i_req = 1'b1; bus.i_addr = 32'h4;
        bus.d_req = 1'b1; bus.d_addr = 32'h10; bus.d_we = 1'b0; bus.d_wdata = '0;
        clr = 1'b1;
        tick();
        model_on = 1'b1;
        chk("rst_m_en", 32'(bus.m_en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        tick();
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_i_rdata", bus.i_rdata, 0);
        clr = 1'b0;
        tick();
        chk("first_owner_d", 32'(bus.owner), 1);
        chk("first_m_addr", bus.m_addr, 32'h10);
        ticks(2);
        chk("cont_d_ack", 32'(bus.d_ack), 1);
        chk("cont_d_rdata", bus.d_rdata, 32'h1000_0044);
        bus.d_req = 1'b0;
        tick();
        chk("cont_owner_i", 32'(bus.owner), 0);
        ticks(2);
        chk("cont_i_ack", 32'(bus.i_ack), 1);
        chk("cont_i_rdata", bus.i_rdata, 32'h8C01_0004);
        bus.i_req = 1'b0;
        tick();

        // Single fetch.
        bus.i_req = 1'b1; bus.i_addr = 32'h4;
        tick();
        chk("fetch_m_en_c1", 32'(bus.m_en), 1);
        chk("fetch_m_addr", bus.m_addr, 32'h4);
        tick();
        chk("fetch_m_en_c2", 32'(bus.m_en), 1);
        chk("fetch_no_ack_c2", 32'(bus.i_ack), 0);
        tick();
        chk("fetch_ack_c3", 32'(bus.i_ack), 1);
        bus.i_req = 1'b0;
        tick();
        chk("fetch_ack_c4", 32'(bus.i_ack), 0);
        chk("fetch_m_en_c4", 32'(bus.m_en), 0);

        // Starvation: D, D, then forced I grant at c6, D again at c9.
        bus.i_req = 1'b1; bus.i_addr = 32'h8;
        bus.d_req = 1'b1; bus.d_addr = 32'h20; bus.d_we = 1'b0;
        ticks(3);
        chk("starve_d_ack1", 32'(bus.d_ack), 1);
        ticks(3);
        chk("starve_d_ack2", 32'(bus.d_ack), 1);
        tick();
        chk("starve_owner_i", 32'(bus.owner), 0);
        chk("starve_m_addr", bus.m_addr, 32'h8);
        ticks(2);
        chk("starve_i_ack", 32'(bus.i_ack), 1);
        bus.i_req = 1'b0;
        tick();
        chk("starve_d_resume", 32'(bus.owner), 1);
        ticks(2);
        chk("starve_d_ack3", 32'(bus.d_ack), 1);
        chk("starve_d_rdata", bus.d_rdata, 32'h1000_0088);
        bus.d_req = 1'b0;
        tick();

        // Write, then read it back.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h4; bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("wr_m_we", 32'(bus.m_we), 1);
        chk("wr_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
        ticks(2);
        chk("wr_d_ack", 32'(bus.d_ack), 1);
        chk("wr_d_rdata_kept", bus.d_rdata, 32'h1000_0088);
        bus.d_we = 1'b0;
        ticks(3);
        chk("rd_back", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_req = 1'b0;
        tick();

        // Abort a fetch mid-access.
        bus.i_req = 1'b1; bus.i_addr = 32'hC;
        tick();
        chk("abort_m_en_c1", 32'(bus.m_en), 1);
        clr = 1'b1; bus.i_req = 1'b0;
        tick();
        chk("abort_m_en_c2", 32'(bus.m_en), 0);
        chk("abort_busy_c2", 32'(bus.busy), 0);
        clr = 1'b0;
        tick();
        chk("abort_no_ack_c3", 32'(bus.i_ack), 0);
        tick();
        chk("abort_no_ack_c4", 32'(bus.i_ack), 0);
        bus.i_req = 1'b1;
        ticks(3);
        chk("abort_next_ack", 32'(bus.i_ack), 1);
        chk("abort_next_rdata", bus.i_rdata, 32'h1000_0033);
        bus.i_req = 1'b0;
        tick();

        // Randomized traffic; requests are held until their ack, then dropped or renewed.
        for (int n = 0; n < 4000; n++) begin
            clr = ($urandom_range(0, 199) == 0);
            if (!bus.i_req || bus.i_ack) begin
                if ($urandom_range(0, 2) != 0) begin
                    bus.i_req  = 1'b1;
                    bus.i_addr = $urandom & 32'hFFFF_FFFC;
                end else begin
                    bus.i_req = 1'b0;
                end
            end
            if (!bus.d_req || bus.d_ack) begin
                if ($urandom_range(0, 2) != 0) begin
                    bus.d_req   = 1'b1;
                    bus.d_addr  = $urandom & 32'hFFFF_FFFC;
                    bus.d_we    = 1'($urandom_range(0, 1));
                    bus.d_wdata = $urandom;
                end else begin
                    bus.d_req = 1'b0;
                end
            end
            tick();
        end
        clr = 1'b0;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        ticks(WAIT + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
